layer_input_collector: RTL and testbench
========================================

Name: layer_input_collector

Overview:
- Serial-to-parallel counterpart of the inter-layer shift buffer: collects one floating-point element per accepted beat from a serial producer (nonlinear unit / ALU output stream).
- Assembles NUM_NEURONS elements into one packed layer word, then presents it to the next layer with a valid/ready handshake.
- Also latches the per-word error and net-derivative sidebands, so they travel with the assembled word.

Parameters:
- NUM_NEURONS, 4: elements per assembled layer word; legal range ≥ 2.
- NUM_NONLIN, 1: number of nonlinear modules; sets the net-derivative sideband width.
- BIT_WIDTH, 32: floating-point size.
- EXTRA_BITS, 2: FloPoCo exception bits; legal values are 0 or 2.
- Derived constants:
  - EW = BIT_WIDTH + EXTRA_BITS
  - CW = $clog2(NUM_NEURONS + 1)

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- elem_in  in  EW  serial element.
- elem_valid  in  1  elem_in is valid this cycle.
- elem_ready  out  1  collector can accept elem_in.
- error_in  in  EW  error sideband, sampled with the last element of a word.
- net_derivative_in  in  NUM_NONLIN*EW  sideband, sampled with the last element of a word.
- flush  in  1  synchronous abort of a partial word.
- layer_word  out  NUM_NEURONS*EW  assembled word; element k occupies bits [k*EW +: EW].
- layer_valid  out  1  layer_word and sidebands are valid.
- layer_ready  in  1  consumer accepts layer_word.
- error_out  out  EW  latched error.
- net_derivative_out  out  NUM_NONLIN*EW  latched net derivative.
- elem_count  out  CW  number of elements held in the current partial word.

Behaviour:
- Reset (rst_n low, asynchronous): state = COLLECT; count = 0; layer_word = 0; error_out = 0; net_derivative_out = 0; layer_valid = 0.
- elem_ready = (state == COLLECT) | (state == FULL & layer_ready).
- An element is accepted when elem_valid & elem_ready.
- State COLLECT:
  - Each accepted beat writes elem_in into slot[count] and increments count.
  - Element order is LSB-first: the first element accepted lands in bits [EW-1:0]. This mirrors the shift buffer, which emits its lowest slot first.
  - When the accepted beat writes slot NUM_NEURONS-1: error_in and net_derivative_in are latched the same cycle, count returns to 0, and the state moves to FULL.
- State FULL:
  - layer_valid = 1; layer_word and the sidebands are held stable.
  - layer_ready high: the word is released, and the state moves to COLLECT on the next edge.
  - layer_ready & elem_valid in the same cycle: the word is released and the new element is written to slot 0 in that same cycle (count = 1, state = COLLECT). There is no bubble.
- Latency: layer_valid rises on the cycle after the last element is accepted. Back-to-back throughput is one element per clock.
- Slots not yet rewritten keep their old data. Consumers must use layer_word only while layer_valid is high.
- flush:
  - In COLLECT: clears count to 0, and any element accepted the same cycle is dropped.
  - In FULL: ignored (a completed word is never discarded).
- elem_valid while elem_ready is low: the element is not consumed and the producer must hold it.
- X on elem_in is don't-care when elem_valid is low.

Optional Feature:
- Macro: LAYER_INPUT_COLLECTOR_EXC_FLAG_EN.
- Defined, and EXTRA_BITS == 2:
  - Adds an output port exc_flag (1 bit).
  - exc_flag is sticky; it sets when an accepted element has top bits [EW-1:EW-2] equal to 2'b10 (infinity) or 2'b11 (NaN).
  - It clears on the handshake that releases the word, or on reset.
- Not defined: the port is absent and there is no extra logic.
- Defined with EXTRA_BITS == 0: the flag is tied to 0.

Decomposition:
- Shared package nn_layer_pkg holds:
  - EW computation and a state enum {COLLECT, FULL};
  - the function elem_slot(k), returning the bit offset k*EW;
  - FloPoCo exception encodings.
- No sub-module is needed. An optional generic slot_writer (one-hot write decode into the packed register) is acceptable but not required.

Test Plan:
- Basic assembly: NUM_NEURONS=4, EW=34; feed 1, 2, 3, 4 back-to-back, with layer_ready low -> layer_valid = 1 one cycle after element 4; layer_word = {4,3,2,1}; elem_ready = 0.
- Zero-bubble release: hold FULL, then assert layer_ready with elem_valid (5) in the same cycle -> layer_valid = 0 next cycle, elem_count = 1, slot 0 = 5.
- Sideband capture: error_in = 0xAA with the 4th element, then change it to 0x55 -> error_out stays 0xAA until the next word completes.
- Flush: accept 2 elements, then assert flush with elem_valid (9) -> elem_count = 0, the 9 is dropped; the next 4 elements form a clean word.
- Async reset: drop rst_n mid-word (count = 3) without a clock edge -> outputs zero immediately; layer_valid = 0; elem_count = 0.
- With LAYER_INPUT_COLLECTOR_EXC_FLAG_EN: feed one element with top bits 2'b11 -> exc_flag = 1 through FULL, and 0 after the release handshake.

Source files
------------

// File: rtl/nn_layer_pkg.sv
// -----------------------------------------------------------------------------
// nn_layer_pkg
// Shared definitions for the inter-layer data path:
//   - element width helper (floating-point bits + FloPoCo exception bits)
//   - collector state encoding {COLLECT, FULL}
//   - elem_slot(): bit offset of element k inside a packed layer word
//   - FloPoCo exception encodings (top two bits of an element)
// -----------------------------------------------------------------------------
package nn_layer_pkg;

  localparam int BIT_WIDTH_DEFAULT  = 32;
  localparam int EXTRA_BITS_DEFAULT = 2;

  // Element width: IEEE-style payload plus FloPoCo exception field.
  function automatic int elem_width(input int bit_width, input int extra_bits);
    return bit_width + extra_bits;
  endfunction

  localparam int EW_DEFAULT = elem_width(BIT_WIDTH_DEFAULT, EXTRA_BITS_DEFAULT);

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } collector_state_e;

  // FloPoCo exception field values.
  localparam logic [1:0] EXC_ZERO   = 2'b00;
  localparam logic [1:0] EXC_NORMAL = 2'b01;
  localparam logic [1:0] EXC_INF    = 2'b10;
  localparam logic [1:0] EXC_NAN    = 2'b11;

  // Bit offset of element k in a packed word (element 0 at the LSBs).
  function automatic int elem_slot(input int k, input int ew = EW_DEFAULT);
    return k * ew;
  endfunction

endpackage

// File: rtl/layer_input_collector.sv
// -----------------------------------------------------------------------------
// layer_input_collector
// Serial-to-parallel collector: accepts one element per handshake beat from a
// serial producer, packs NUM_NEURONS of them LSB-first into one layer word and
// offers that word (with error / net-derivative sidebands latched on the last
// beat) to the next layer over a valid/ready handshake.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   elem_in/_valid/_ready serial element input handshake
//   error_in              error sideband, sampled with the last element
//   net_derivative_in     net-derivative sideband, sampled with the last element
//   flush                 aborts a partial word (ignored while a word is held)
//   layer_word/_valid     assembled word, element k at [k*EW +: EW]
//   layer_ready           consumer accepts layer_word
//   error_out             latched error sideband
//   net_derivative_out    latched net-derivative sideband
//   elem_count            elements held in the current partial word
//   exc_flag              (only with LAYER_INPUT_COLLECTOR_EXC_FLAG_EN) sticky
//                         flag: an accepted element was infinity or NaN
//
// Optional feature macro: LAYER_INPUT_COLLECTOR_EXC_FLAG_EN
// -----------------------------------------------------------------------------
module layer_input_collector
  import nn_layer_pkg::*;
#(
  parameter  int NUM_NEURONS = 4,
  parameter  int NUM_NONLIN  = 1,
  parameter  int BIT_WIDTH   = 32,
  parameter  int EXTRA_BITS  = 2,
  localparam int EW          = elem_width(BIT_WIDTH, EXTRA_BITS),
  localparam int CW          = $clog2(NUM_NEURONS + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [EW-1:0]               elem_in,
  input  logic                        elem_valid,
  output logic                        elem_ready,
  input  logic [EW-1:0]               error_in,
  input  logic [NUM_NONLIN*EW-1:0]    net_derivative_in,
  input  logic                        flush,
  output logic [NUM_NEURONS*EW-1:0]   layer_word,
  output logic                        layer_valid,
  input  logic                        layer_ready,
  output logic [EW-1:0]               error_out,
  output logic [NUM_NONLIN*EW-1:0]    net_derivative_out,
`ifdef LAYER_INPUT_COLLECTOR_EXC_FLAG_EN
  output logic                        exc_flag,
`endif
  output logic [CW-1:0]               elem_count
);

  localparam logic [CW-1:0] LAST_SLOT = CW'(NUM_NEURONS - 1);

  collector_state_e          state_q, state_d;
  logic [CW-1:0]             count_q, count_d;
  logic [EW-1:0]             error_q;
  logic [NUM_NONLIN*EW-1:0]  nd_q;

  logic                      wr_en;        // write elem_in into slot wr_idx
  logic [CW-1:0]             wr_idx;
  logic                      latch_side;   // last element of a word accepted
  logic                      release_word; // held word handed to consumer

  // ---------------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    wr_en        = 1'b0;
    wr_idx       = count_q;
    latch_side   = 1'b0;
    release_word = (state_q == FULL) && layer_ready;
    elem_ready   = (state_q == COLLECT) || release_word;
    layer_valid  = (state_q == FULL);

    case (state_q)
      COLLECT: begin
        if (flush) begin
          // Abort the partial word; a beat accepted this cycle is discarded.
          count_d = '0;
        end else if (elem_valid) begin
          wr_en = 1'b1;
          if (count_q == LAST_SLOT) begin
            latch_side = 1'b1;
            count_d    = '0;
            state_d    = FULL;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      FULL: begin
        if (release_word) begin
          state_d = COLLECT;
          // Zero-bubble restart: the beat arriving with the release handshake
          // becomes element 0 of the next word.
          if (elem_valid) begin
            wr_en   = 1'b1;
            wr_idx  = '0;
            count_d = CW'(1);
          end
        end
      end
      default: begin
        state_d = COLLECT;
        count_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, count and sideband registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      count_q <= '0;
      error_q <= '0;
      nd_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (latch_side) begin
        error_q <= error_in;
        nd_q    <= net_derivative_in;
      end
    end
  end

  assign elem_count         = count_q;
  assign error_out          = error_q;
  assign net_derivative_out = nd_q;

  // ---------------------------------------------------------------------------
  // Slot registers: one-hot write decode, stale slots keep their old data.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_NEURONS; gi++) begin : g_slot
    logic [EW-1:0] slot_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        slot_q <= '0;
      end else if (wr_en && (wr_idx == CW'(gi))) begin
        slot_q <= elem_in;
      end
    end

    assign layer_word[elem_slot(gi, EW) +: EW] = slot_q;
  end

`ifdef LAYER_INPUT_COLLECTOR_EXC_FLAG_EN
  // ---------------------------------------------------------------------------
  // Sticky exception flag for the word under assembly / being held.
  // ---------------------------------------------------------------------------
  if (EXTRA_BITS == 2) begin : g_exc
    logic exc_q, exc_d;
    logic elem_exc;

    assign elem_exc = (elem_in[EW-1 -: 2] == EXC_INF) ||
                      (elem_in[EW-1 -: 2] == EXC_NAN);

    // Clear on release first, so an exceptional element entering on the
    // release cycle is attributed to the new word.
    always_comb begin
      exc_d = exc_q;
      if (release_word) exc_d = 1'b0;
      if (wr_en && elem_exc) exc_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        exc_q <= 1'b0;
      end else begin
        exc_q <= exc_d;
      end
    end

    assign exc_flag = exc_q;
  end else begin : g_no_exc
    assign exc_flag = 1'b0;
  end
`endif

endmodule

// File: tb/tb_layer_input_collector.sv
module tb_layer_input_collector;

  localparam int NN = 4;
  localparam int NL = 1;
  localparam int BW = 32;
  localparam int XB = 2;
  localparam int EW = BW + XB;
  localparam int CW = $clog2(NN + 1);

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [EW-1:0]        elem_in;
  logic                 elem_valid;
  logic                 elem_ready;
  logic [EW-1:0]        error_in;
  logic [NL*EW-1:0]     net_derivative_in;
  logic                 flush;
  logic [NN*EW-1:0]     layer_word;
  logic                 layer_valid;
  logic                 layer_ready;
  logic [EW-1:0]        error_out;
  logic [NL*EW-1:0]     net_derivative_out;
  logic [CW-1:0]        elem_count;
`ifdef LAYER_INPUT_COLLECTOR_EXC_FLAG_EN
  logic                 exc_flag;
`endif

  layer_input_collector #(
    .NUM_NEURONS(NN), .NUM_NONLIN(NL), .BIT_WIDTH(BW), .EXTRA_BITS(XB)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .elem_in(elem_in), .elem_valid(elem_valid), .elem_ready(elem_ready),
    .error_in(error_in), .net_derivative_in(net_derivative_in), .flush(flush),
    .layer_word(layer_word), .layer_valid(layer_valid), .layer_ready(layer_ready),
    .error_out(error_out), .net_derivative_out(net_derivative_out),
`ifdef LAYER_INPUT_COLLECTOR_EXC_FLAG_EN
    .exc_flag(exc_flag),
`endif
    .elem_count(elem_count)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- scoreboard
  typedef struct {
    logic [NN*EW-1:0] word;
    logic [EW-1:0]    err;
    logic [NL*EW-1:0] nd;
  } exp_t;

  exp_t          exp_q[$];
  logic [EW-1:0] part[$];   // elements of the partial word, in arrival order
  bit            m_full;    // a completed word is waiting for the consumer
  bit            m_exc;     // an inf/NaN element arrived since last release
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_exc(input logic [EW-1:0] d);
    // infinity (2'b10) or NaN (2'b11) in the exception field
    return (d[EW-1:EW-2] == 2'b10) || (d[EW-1:EW-2] == 2'b11);
  endfunction

  // One clock of stimulus: drive, compare cycle-level outputs, advance model.
  task automatic cycle(input bit v, input logic [EW-1:0] d, input bit r, input bit f,
                       input logic [EW-1:0] e, input logic [NL*EW-1:0] n);
    bit   exp_ready;
    exp_t x;
    @(negedge clk);
    elem_valid = v; elem_in = d; layer_ready = r; flush = f;
    error_in = e; net_derivative_in = n;
    #1;
    exp_ready = !m_full || r;
    chk("elem_ready", 256'(elem_ready), 256'(exp_ready));
    chk("layer_valid", 256'(layer_valid), 256'(m_full));
    chk("elem_count", 256'(elem_count), 256'(part.size()));
`ifdef LAYER_INPUT_COLLECTOR_EXC_FLAG_EN
    chk("exc_flag", 256'(exc_flag), 256'(m_exc));
`endif
    $display("cyc v=%0b d=%0h r=%0b f=%0b held=%0d full=%0b", v, d, r, f, part.size(), m_full);
    if (m_full) begin
      if (r) begin
        m_full = 0;
        m_exc  = 0;
        if (v) begin
          part.push_back(d);
          if (is_exc(d)) m_exc = 1;
        end
      end
    end else if (f) begin
      part.delete();
    end else if (v) begin
      part.push_back(d);
      if (is_exc(d)) m_exc = 1;
      if (part.size() == NN) begin
        x.word = '0;
        foreach (part[k]) x.word[k*EW +: EW] = part[k];
        x.err = e;
        x.nd  = n;
        exp_q.push_back(x);
        part.delete();
        m_full = 1;
      end
    end
  endtask

  // Monitor: whenever a word is presented, it must match the oldest expected
  // word; it is retired on the handshake.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n === 1'b1 && layer_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 256'(layer_valid), 256'(0));
        end else begin
          chk("layer_word", 256'(layer_word), 256'(exp_q[0].word));
          chk("error_out", 256'(error_out), 256'(exp_q[0].err));
          chk("net_deriv_out", 256'(net_derivative_out), 256'(exp_q[0].nd));
          if (layer_ready === 1'b1) begin
            $display("word released %0h err=%0h", layer_word, error_out);
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic idle(input bit r);
    cycle(0, '0, r, 0, '0, '0);
  endtask

  task automatic feed(input logic [EW-1:0] d, input bit r);
    cycle(1, d, r, 0, 34'h0, 34'h0);
  endtask

  task automatic async_reset();
    #2;
    elem_valid = 0; layer_ready = 0; flush = 0;
    rst_n = 0;
    #1;
    chk("rst_layer_word", 256'(layer_word), 256'(0));
    chk("rst_layer_valid", 256'(layer_valid), 256'(0));
    chk("rst_elem_count", 256'(elem_count), 256'(0));
    chk("rst_error_out", 256'(error_out), 256'(0));
    chk("rst_nd_out", 256'(net_derivative_out), 256'(0));
    chk("rst_elem_ready", 256'(elem_ready), 256'(1));
    $display("async reset applied");
    part.delete(); exp_q.delete(); m_full = 0; m_exc = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [EW-1:0] d;
    elem_valid = 0; elem_in = '0; layer_ready = 0; flush = 0;
    error_in = '0; net_derivative_in = '0;
    rst_n = 0;
    m_full = 0; m_exc = 0;
    #2;
    chk("init_layer_word", 256'(layer_word), 256'(0));
    chk("init_layer_valid", 256'(layer_valid), 256'(0));
    chk("init_elem_count", 256'(elem_count), 256'(0));
    chk("init_error_out", 256'(error_out), 256'(0));
    @(negedge clk);
    rst_n = 1;

    // Basic assembly with sideband 0xAA on the last element, then sideband
    // changes while the word is held.
    feed(34'd1, 0); feed(34'd2, 0); feed(34'd3, 0);
    cycle(1, 34'd4, 0, 0, 34'hAA, 34'h123);
    cycle(0, '0, 0, 0, 34'h55, 34'h77);
    chk("basic_word", 256'(layer_word), 256'({34'd4, 34'd3, 34'd2, 34'd1}));
    cycle(0, '0, 0, 0, 34'h55, 34'h77);

    // Zero-bubble release: element 5 enters with the release handshake.
    feed(34'd5, 1);
    idle(0);
    chk("bubble_slot0", 256'(layer_word[EW-1:0]), 256'(5));

    // Flush with a concurrent element after two held elements.
    feed(34'd6, 0);
    cycle(1, 34'd9, 0, 1, '0, '0);
    feed(34'd11, 0); feed(34'd12, 0); feed(34'd13, 0);
    cycle(1, 34'd14, 0, 0, 34'h3C, 34'h2);
    idle(0);
    idle(1);

    // Async reset mid-word with three elements held.
    feed(34'd21, 0); feed(34'd22, 0); feed(34'd23, 0);
    idle(0);
    async_reset();

    // Exception element (NaN field) followed by normal ones.
    feed({2'b11, 32'h7FC0_0000}, 0);
    feed({2'b01, 32'h3F80_0000}, 0);
    feed({2'b01, 32'h4000_0000}, 0);
    feed({2'b01, 32'h4040_0000}, 0);
    idle(0); idle(0);
    idle(1);
    idle(0);

    // Randomised traffic.
    for (int i = 0; i < 2000; i++) begin
      d = {(($urandom_range(0, 15) == 0) ? 2'b11 : 2'b01), 32'($urandom)};
      cycle($urandom_range(0, 9) < 7, d, $urandom_range(0, 1) == 1,
            $urandom_range(0, 19) == 0, {2'($urandom), 32'($urandom)},
            {2'($urandom), 32'($urandom)});
    end

    // Drain the last word, if any.
    idle(1); idle(1); idle(0);
    chk("scoreboard_empty", 256'(exp_q.size()), 256'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
